mem_stage: RTL and testbench

- Memory-access pipeline stage; sits directly downstream of the EXE stage and upstream of the WB stage.
- Registers the EXE payload and receives the synchronous data-SRAM read data one cycle after EXE issued the request.
- Extracts and extends the load result (byte/half/word), selects the final writeback value, and drives the WB handshake.
- Exports destination, write-enable and result for forwarding and load-use hazard detection in ID.

---
 rtl/mem_stage.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage.
//
//   This stage sits between EXE and WB. It does the following:
//   - Registers the EXE payload.
//   - Picks up the synchronous data-SRAM read data in the instruction's first
//     MEM cycle.
//   - Extracts and extends byte, half and word loads.
//   - Selects the final writeback value and drives the WB valid/allowin
//     handshake.
//   - Exports the destination, write-enable and result for forwarding and
//     for load-use hazard detection in ID.
//
// Ports:
//   clk             : system clock, posedge
//   reset           : synchronous active-high reset
//   ws_allowin      : WB can accept an instruction this cycle
//   ms_allowin      : MEM can accept an instruction from EXE this cycle
//   es2ms_valid     : EXE presents a valid instruction
//   es2ms_bus       : {pc, alu_result, res_from_mem, dest, gr_we, ld_op}
//   ms2ws_valid     : MEM presents a valid instruction to WB
//   ms2ws_bus       : {pc, final_result, gr_we, dest}
//   data_sram_rdata : SRAM read data, valid only in the first MEM cycle
//   mem_dest        : destination register of the MEM instruction
//   mem_rf_we       : MEM instruction writes the register file
//   mem_fwd_data    : final result, for forwarding
//   mem_is_load     : MEM instruction is a load (load-use stall in ID)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    // Both widths are fixed by the bus field layouts below.
    parameter int ES2MS_W = 76,
    parameter int MS2WS_W = 70
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    input  logic               es2ms_valid,
    input  logic [ES2MS_W-1:0] es2ms_bus,
    output logic               ms2ws_valid,
    output logic [MS2WS_W-1:0] ms2ws_bus,
    input  logic [31:0]        data_sram_rdata,
    output logic [4:0]         mem_dest,
    output logic               mem_rf_we,
    output logic [31:0]        mem_fwd_data,
    output logic               mem_is_load
);

    // Bit positions inside the one-hot ld_op field {ld_w, ld_h, ld_hu, ld_b, ld_bu}
    localparam int C_LD_W  = 4;
    localparam int C_LD_H  = 3;
    localparam int C_LD_HU = 2;
    localparam int C_LD_B  = 1;
    localparam int C_LD_BU = 0;

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic        r_ms_valid;
    logic [31:0] r_pc;
    logic [31:0] r_alu_result;
    logic        r_res_from_mem;
    logic [4:0]  r_dest;
    logic        r_gr_we;
    logic [4:0]  r_ld_op;

    // Hold buffer for SRAM read data across WB back-pressure
    logic [31:0] r_rbuf;
    logic        r_rbuf_valid;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic        w_ms_ready_go;
    logic        w_es_accept;
    logic [31:0] w_rdata;
    logic [1:0]  w_addr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_result;
    logic [31:0] w_final_result;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // MEM never needs more than one cycle, so it is always ready to leave.
    assign w_ms_ready_go = 1'b1;
    assign ms_allowin    = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms2ws_valid   = r_ms_valid && w_ms_ready_go;
    assign w_es_accept   = es2ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es2ms_valid;
        end
    end

    // The payload only moves on a real transfer, so the bus holds its last
    // value while the stage is empty or stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= 32'd0;
            r_alu_result   <= 32'd0;
            r_res_from_mem <= 1'b0;
            r_dest         <= 5'd0;
            r_gr_we        <= 1'b0;
            r_ld_op        <= 5'd0;
        end else if (w_es_accept) begin
            r_pc           <= es2ms_bus[75:44];
            r_alu_result   <= es2ms_bus[43:12];
            r_res_from_mem <= es2ms_bus[11];
            r_dest         <= es2ms_bus[10:6];
            r_gr_we        <= es2ms_bus[5];
            r_ld_op        <= es2ms_bus[4:0];
        end
    end

    // ------------------------------------------------------------------
    // Read-data hold buffer
    // ------------------------------------------------------------------
    // The SRAM only returns the data in the first MEM cycle. If WB stalls
    // that cycle, the data is captured here and used for the rest of the
    // stall. The buffer clears as soon as WB accepts. Because capture needs
    // !ws_allowin, clear and capture can never fire together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rbuf       <= 32'd0;
            r_rbuf_valid <= 1'b0;
        end else if (ws_allowin) begin
            r_rbuf_valid <= 1'b0;
        end else if (r_ms_valid && !r_rbuf_valid) begin
            r_rbuf       <= data_sram_rdata;
            r_rbuf_valid <= 1'b1;
        end
    end

    assign w_rdata = r_rbuf_valid ? r_rbuf : data_sram_rdata;

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    assign w_addr = r_alu_result[1:0];

    always_comb begin
        w_byte = w_rdata[7:0];
        case (w_addr)
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
    end

    // Halfword selection ignores addr[0]; misalignment is not trapped here.
    assign w_half = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];

    always_comb begin
        w_load_result = w_rdata;
        if (r_ld_op[C_LD_W]) begin
            w_load_result = w_rdata;
        end else if (r_ld_op[C_LD_H]) begin
            w_load_result = {{16{w_half[15]}}, w_half};
        end else if (r_ld_op[C_LD_HU]) begin
            w_load_result = {16'd0, w_half};
        end else if (r_ld_op[C_LD_B]) begin
            w_load_result = {{24{w_byte[7]}}, w_byte};
        end else if (r_ld_op[C_LD_BU]) begin
            w_load_result = {24'd0, w_byte};
        end
    end

    assign w_final_result = r_res_from_mem ? w_load_result : r_alu_result;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ms2ws_bus    = {r_pc, w_final_result, r_gr_we, r_dest};

    assign mem_dest     = r_dest;
    assign mem_rf_we    = r_ms_valid && r_gr_we;
    assign mem_fwd_data = w_final_result;
    assign mem_is_load  = r_ms_valid && r_res_from_mem;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard testbench for mem_stage. Stimulus pushes the
//               expected WB payload when EXE hands an instruction over. An
//               independent monitor compares on every negedge the DUT holds
//               an instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es2ms_valid;
    logic [75:0] es2ms_bus;
    logic        ms2ws_valid;
    logic [69:0] ms2ws_bus;
    logic [31:0] data_sram_rdata;
    logic [4:0]  mem_dest;
    logic        mem_rf_we;
    logic [31:0] mem_fwd_data;
    logic        mem_is_load;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es2ms_valid     (es2ms_valid),
        .es2ms_bus       (es2ms_bus),
        .ms2ws_valid     (ms2ws_valid),
        .ms2ws_bus       (ms2ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_dest        (mem_dest),
        .mem_rf_we       (mem_rf_we),
        .mem_fwd_data    (mem_fwd_data),
        .mem_is_load     (mem_is_load)
    );

    typedef struct packed {
        logic        is_load;
        logic [69:0] bus;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_valid = 1'b0;   // reference occupancy of the MEM stage
    exp_t mon_e;
    bit   mon_ev;

    localparam logic [4:0] LD_W  = 5'b10000;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b00100;
    localparam logic [4:0] LD_B  = 5'b00010;
    localparam logic [4:0] LD_BU = 5'b00001;

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [75:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                       input logic rfm, input logic [4:0] dest,
                                       input logic we, input logic [4:0] ldop);
        return {pc, alu, rfm, dest, we, ldop};
    endfunction

    // Reference load extraction by shifting, masking and adding the sign extension.
    function automatic logic [31:0] load_model(input logic [4:0] ldop, input logic [1:0] a,
                                               input logic [31:0] rd);
        longint unsigned v;
        if (ldop == LD_W) return rd;
        if (ldop == LD_H || ldop == LD_HU) begin
            v = longint'((rd >> (16 * int'(a[1]))) & 32'h0000FFFF);
            if (ldop == LD_H && v >= 64'h8000) v = v + 64'hFFFF0000;
            return v[31:0];
        end
        v = longint'((rd >> (8 * int'(a))) & 32'h000000FF);
        if (ldop == LD_B && v >= 64'h80) v = v + 64'hFFFFFF00;
        return v[31:0];
    endfunction

    function automatic exp_t expect_of(input logic [75:0] b, input logic [31:0] rd);
        exp_t        e;
        logic [31:0] pc, alu, res;
        pc        = b[75:44];
        alu       = b[43:12];
        res       = b[11] ? load_model(b[4:0], alu[1:0], rd) : alu;
        e.is_load = b[11];
        e.bus     = {pc, res, b[5], b[10:6]};
        return e;
    endfunction

    // One cycle of stimulus, entered at posedge+1. 'rd' is what the SRAM
    // shows next cycle: real data if this instruction is accepted, junk otherwise.
    task automatic step(input bit v, input logic [75:0] bus, input bit ws, input logic [31:0] rd);
        bit acc;
        es2ms_valid = v;
        es2ms_bus   = bus;
        ws_allowin  = ws;
        acc = v && (!m_valid || ws);
        @(posedge clk);
        #1;
        if (acc) begin
            q.push_back(expect_of(bus, rd));
            m_valid = 1'b1;
        end else if (!m_valid || ws) begin
            m_valid = 1'b0;
        end
        data_sram_rdata = rd;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        es2ms_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_valid = 1'b0;
        data_sram_rdata = $urandom;
        chk("rst_ms2ws_valid", 70'(ms2ws_valid), 70'(1'b0));
        chk("rst_mem_rf_we",   70'(mem_rf_we),   70'(1'b0));
        chk("rst_mem_is_load", 70'(mem_is_load), 70'(1'b0));
        chk("rst_ms2ws_bus",   ms2ws_bus,        70'd0);
        chk("rst_mem_dest",    70'(mem_dest),    70'd0);
        chk("rst_mem_fwd",     70'(mem_fwd_data), 70'd0);
        chk("rst_ms_allowin",  70'(ms_allowin),  70'(1'b1));
    endtask

    // Monitor: compares whatever the DUT presents to WB against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            mon_ev = (q.size() > 0);
            chk("ms2ws_valid", 70'(ms2ws_valid), 70'(mon_ev));
            chk("ms_allowin",  70'(ms_allowin),  70'(!mon_ev || ws_allowin));
            if (mon_ev) begin
                mon_e = q[0];
                chk("ms2ws_bus",    ms2ws_bus,           mon_e.bus);
                chk("mem_dest",     70'(mem_dest),       70'(mon_e.bus[4:0]));
                chk("mem_rf_we",    70'(mem_rf_we),      70'(mon_e.bus[5]));
                chk("mem_fwd_data", 70'(mem_fwd_data),   70'(mon_e.bus[37:6]));
                chk("mem_is_load",  70'(mem_is_load),    70'(mon_e.is_load));
                if (ws_allowin) void'(q.pop_front());
            end else begin
                chk("idle_mem_rf_we",   70'(mem_rf_we),   70'(1'b0));
                chk("idle_mem_is_load", 70'(mem_is_load), 70'(1'b0));
            end
        end
    end

    initial begin
        logic [75:0] b;
        logic [4:0]  ld;
        reset           = 1'b1;
        ws_allowin      = 1'b0;
        es2ms_valid     = 1'b0;
        es2ms_bus       = '0;
        data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        step(1'b0, '0, 1'b1, $urandom);

        // ALU passthrough
        step(1'b1, mk(32'h1C000004, 32'h12345678, 1'b0, 5'd5, 1'b1, 5'd0), 1'b1, $urandom);
        // Byte loads
        step(1'b1, mk(32'h1C000008, 32'h00001003, 1'b1, 5'd6, 1'b1, LD_B),  1'b1, 32'h80FF7F01);
        step(1'b1, mk(32'h1C00000C, 32'h00001003, 1'b1, 5'd7, 1'b1, LD_BU), 1'b1, 32'h80FF7F01);
        step(1'b1, mk(32'h1C000010, 32'h00001001, 1'b1, 5'd8, 1'b1, LD_B),  1'b1, 32'h80FF7F01);
        // Half and word loads
        step(1'b1, mk(32'h1C000014, 32'h00002002, 1'b1, 5'd9,  1'b1, LD_H),  1'b1, 32'h8001F00F);
        step(1'b1, mk(32'h1C000018, 32'h00002000, 1'b1, 5'd10, 1'b1, LD_HU), 1'b1, 32'h8001F00F);
        step(1'b1, mk(32'h1C00001C, 32'h00002004, 1'b1, 5'd11, 1'b1, LD_W),  1'b1, 32'h8001F00F);
        step(1'b0, '0, 1'b1, $urandom);

        // Stall while the SRAM output changes; EXE keeps offering a new instruction.
        step(1'b1, mk(32'h1C000020, 32'h00003000, 1'b1, 5'd12, 1'b1, LD_W), 1'b1, 32'hCAFEF00D);
        b = mk(32'h1C000024, 32'h00000055, 1'b0, 5'd13, 1'b1, 5'd0);
        repeat (3) step(1'b1, b, 1'b0, 32'hDEADBEEF);
        step(1'b1, b, 1'b1, $urandom);
        step(1'b0, '0, 1'b1, $urandom);

        // Back-to-back, stall, then reset in the middle of the stall.
        step(1'b1, mk(32'h1C000030, 32'h00004001, 1'b1, 5'd14, 1'b1, LD_B), 1'b1, 32'h11223344);
        step(1'b1, mk(32'h1C000034, 32'h00004002, 1'b1, 5'd15, 1'b1, LD_H), 1'b1, 32'h99887766);
        step(1'b1, mk(32'h1C000038, 32'h00000077, 1'b0, 5'd16, 1'b1, 5'd0), 1'b0, 32'h0BADF00D);
        step(1'b1, mk(32'h1C000038, 32'h00000077, 1'b0, 5'd16, 1'b1, 5'd0), 1'b0, 32'h0BADF00D);
        ws_allowin = 1'b0;
        do_reset();
        repeat (2) step(1'b0, '0, 1'b0, $urandom);
        // A fresh stalled load after reset must use its own first-cycle data.
        step(1'b1, mk(32'h1C000040, 32'h00005003, 1'b1, 5'd17, 1'b1, LD_BU), 1'b0, 32'hA5B6C7D8);
        step(1'b0, '0, 1'b0, 32'h01020304);
        step(1'b0, '0, 1'b0, 32'h05060708);
        step(1'b0, '0, 1'b1, $urandom);
        step(1'b0, '0, 1'b1, $urandom);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            ld = 5'b00001 << $urandom_range(0, 4);
            if ($urandom_range(0, 1) == 1)
                b = mk($urandom, $urandom, 1'b1, 5'($urandom), 1'($urandom), ld);
            else
                b = mk($urandom, $urandom, 1'b0, 5'($urandom), 1'($urandom), 5'($urandom));
            step($urandom_range(0, 3) != 0, b, $urandom_range(0, 9) < 7, $urandom);
        end

        repeat (3) step(1'b0, '0, 1'b1, $urandom);
        chk("drain_queue_empty", 70'(q.size()), 70'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
